// File: rtl/stream_prefetcher_pkg.sv
// stream_prefetcher_pkg: shared types and line helpers for the stream prefetcher
package stream_prefetcher_pkg;
  localparam int ADDR_W = 32;
  typedef enum logic [1:0] {PS_IDLE, PS_ACTIVE, PS_STALL} pref_stream_state_e;
  typedef struct packed {
    pref_stream_state_e state;
    logic [ADDR_W-1:0]  last_line;
    logic [ADDR_W-1:0]  next_line;
    logic               parked;
  } pref_stream_t;
  function automatic logic [ADDR_W-1:0] line_of(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] lb);
    return a & ~(lb - 1'b1);
  endfunction
  function automatic logic [ADDR_W-1:0] ahead_of(input logic [ADDR_W-1:0] nl, input logic [ADDR_W-1:0] ll,
                                                 input int ls);
    return ((nl - ll) >> ls) - 1'b1;
  endfunction
endpackage

// File: rtl/stream_prefetcher_rr_arbiter.sv
// stream_prefetcher_rr_arbiter: round-robin one-hot arbiter, search starts after the last grantee
//   clock, reset (async active-low), req[N] requests, advance = grant consumed, grant[N] one-hot
module stream_prefetcher_rr_arbiter #(
  parameter int N = 2,
  localparam int W = N > 1 ? $clog2(N) : 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);
  logic [W-1:0] ptr, nxt;
  always_comb begin
    grant = '0;
    nxt = ptr;
    for (int k = N - 1; k >= 0; k--)
      if (req[W'((int'(ptr) + k) % N)]) begin
        grant = '0;
        grant[W'((int'(ptr) + k) % N)] = 1'b1;
        nxt = W'((int'(ptr) + k + 1) % N);
      end
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) ptr <= '0;
    else if (advance && |grant) ptr <= nxt;
endmodule

// File: rtl/stream_prefetcher.sv
// stream_prefetcher: multi-stream next-line instruction prefetcher between fetch and the Icache
//   clock, reset (async active-low)
//   demand_valid/demand_pc : fetch demand address (any alignment)
//   pref_valid/pref_addr/pref_stream : registered line-aligned prefetch request, held until retire
//   pref_ready : Icache accepts request; hit_valid_line : requested line already resident (skip)
module stream_prefetcher
  import stream_prefetcher_pkg::*;
#(
  parameter int NUM_STREAMS = 2,
  parameter int MAX_DEPTH   = 4,
  parameter int LINE_BYTES  = 8,
  parameter bit STOP_ON_HIT = 1'b0,
  localparam int SW = NUM_STREAMS > 1 ? $clog2(NUM_STREAMS) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              demand_valid,
  input  logic [ADDR_W-1:0] demand_pc,
  output logic [ADDR_W-1:0] pref_addr,
  output logic              pref_valid,
  output logic [SW-1:0]     pref_stream,
  input  logic              pref_ready,
  input  logic              hit_valid_line
);
  localparam logic [ADDR_W-1:0] LB = ADDR_W'(LINE_BYTES);
  localparam logic [ADDR_W-1:0] MD = ADDR_W'(MAX_DEPTH);
  localparam int LS = $clog2(LINE_BYTES);

  pref_stream_t st_q [NUM_STREAMS];
  pref_stream_t st_d [NUM_STREAMS];
  logic [SW-1:0] victim_q, victim_d, mi, ai, gi;
  logic [NUM_STREAMS-1:0] alloc, req, grant;
  logic [ADDR_W-1:0] dl, nl, gaddr;
  logic retire, hit, found, free, wrap, issue;

  assign dl = line_of(demand_pc, LB);
  assign retire = pref_valid & (pref_ready | hit_valid_line);
  assign hit = pref_valid & hit_valid_line;
  assign issue = !pref_valid && |req;

  // Retire is applied first; the demand update then works on the post-retire view,
  // so its last/next fields win and ahead is re-derived from the final pair.
  always_comb begin
    st_d = st_q;
    victim_d = victim_q;
    alloc = '0;
    found = 1'b0;
    free = 1'b0;
    mi = '0;
    ai = '0;
    wrap = 1'b0;
    nl = '0;
    for (int i = 0; i < NUM_STREAMS; i++)
      if (retire && pref_stream == SW'(i)) begin
        {wrap, nl} = {1'b0, st_q[i].next_line} + {1'b0, LB};
        st_d[i].next_line = nl;
        st_d[i].state = wrap ? PS_IDLE :
                        (ahead_of(nl, st_q[i].last_line, LS) >= MD || (hit && STOP_ON_HIT)) ? PS_STALL : st_q[i].state;
        st_d[i].parked = !wrap && hit && STOP_ON_HIT;
      end
    for (int i = NUM_STREAMS - 1; i >= 0; i--) begin
      if (st_d[i].state != PS_IDLE && st_d[i].last_line <= dl && dl < st_d[i].next_line) begin
        found = 1'b1;
        mi = SW'(i);
      end
      if (st_d[i].state == PS_IDLE) begin
        free = 1'b1;
        ai = SW'(i);
      end
    end
    if (demand_valid && !found && !free) begin
      ai = victim_q;
      victim_d = victim_q == SW'(NUM_STREAMS - 1) ? '0 : victim_q + 1'b1;
    end
    for (int i = 0; i < NUM_STREAMS; i++) begin
      if (demand_valid && found && mi == SW'(i)) begin
        st_d[i].last_line = dl;
        if (st_d[i].state == PS_STALL && (st_d[i].parked || ahead_of(st_d[i].next_line, dl, LS) < MD)) begin
          st_d[i].state = PS_ACTIVE;
          st_d[i].parked = 1'b0;
        end
      end
      if (demand_valid && !found && ai == SW'(i)) begin
        alloc[i] = 1'b1;
        st_d[i] = '{state: PS_ACTIVE, last_line: dl, next_line: dl + LB, parked: 1'b0};
      end
    end
  end

  // A stream being reallocated this edge must not issue its stale next_line.
  always_comb begin
    req = '0;
    for (int i = 0; i < NUM_STREAMS; i++) req[i] = st_q[i].state == PS_ACTIVE && !alloc[i];
  end

  stream_prefetcher_rr_arbiter #(.N(NUM_STREAMS)) u_arb (
    .clock  (clock),
    .reset  (reset),
    .req    (req),
    .advance(issue),
    .grant  (grant)
  );

  always_comb begin
    gi = '0;
    gaddr = '0;
    for (int i = 0; i < NUM_STREAMS; i++)
      if (grant[i]) begin
        gi = SW'(i);
        gaddr = st_q[i].next_line;
      end
  end

  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      for (int i = 0; i < NUM_STREAMS; i++) st_q[i] <= '0;
      victim_q <= '0;
      pref_valid <= 1'b0;
      pref_addr <= '0;
      pref_stream <= '0;
    end else begin
      st_q <= st_d;
      victim_q <= victim_d;
      if (issue) begin
        pref_valid <= 1'b1;
        pref_addr <= gaddr;
        pref_stream <= gi;
      end else if (retire || (pref_valid && alloc[pref_stream])) pref_valid <= 1'b0;
    end
endmodule
